// File: rtl/bitwise_pkg.sv
// Shared encodings for the bit-serial bitwise/compare datapath.
// Op codes, sequencer states and the flag inversion rule.
package bitwise_pkg;

  localparam logic [1:0] OP_NE  = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The odd ops report the complement of the accumulated ne/gt result.
  function automatic logic flag_inverted(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// Per-bit logic/compare evaluation for one MSB-first step; purely combinational.
// No state and no flow control: the sequencer owns every register.
module serial_cmp_cell
  import bitwise_pkg::*;
(
  input  logic       sa,
  input  logic       sb,
  input  logic [1:0] op,
  input  logic       ne_seen,
  input  logic       gt_seen,
  input  logic       lt_seen,
  output logic       qbit,
  output logic       ne_nxt,
  output logic       gt_nxt,
  output logic       lt_nxt
);

  always_comb begin
    qbit = 1'b0;
    case (op)
      OP_NE:   qbit = 1'b0;
      OP_XOR:  qbit = sa ^ sb;
      OP_AND:  qbit = sa & sb;
      OP_OR:   qbit = sa | sb;
      default: qbit = 1'b0;
    endcase

    ne_nxt = ne_seen | (sa ^ sb);
    gt_nxt = gt_seen;
    lt_nxt = lt_seen;
    // Walking MSB first, the first differing bit settles the magnitude order.
    if (!gt_seen && !lt_seen) begin
      gt_nxt = sa & ~sb;
      lt_nxt = ~sa & sb;
    end
  end

endmodule

// File: rtl/bitserial_logic_seq.sv
// Bit-serial logic/compare sequencer: WIDTH+1 cycles start-to-done, one op per WIDTH+1 cycles.
// start is ignored while busy; a new op may be accepted in the done cycle, no queueing.
module bitserial_logic_seq
  import bitwise_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [1:0]       op_q, op_d;
  logic             ne_q, ne_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             flag_q, flag_d;

  logic qbit, ne_nxt, gt_nxt, lt_nxt;

  serial_cmp_cell u_cell (
    .sa      (a_sh_q[WIDTH-1]),
    .sb      (b_sh_q[WIDTH-1]),
    .op      (op_q),
    .ne_seen (ne_q),
    .gt_seen (gt_q),
    .lt_seen (lt_q),
    .qbit    (qbit),
    .ne_nxt  (ne_nxt),
    .gt_nxt  (gt_nxt),
    .lt_nxt  (lt_nxt)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    op_d    = op_q;
    ne_d    = ne_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    flag_d  = flag_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          ne_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          count_d = CW'(WIDTH - 1);
        end
      end
      SHIFT: begin
        // Result bits fill in behind operand A as its bits are consumed,
        // so after WIDTH steps the A register holds the finished result.
        a_sh_d  = {a_sh_q[WIDTH-2:0], qbit};
        b_sh_d  = {b_sh_q[WIDTH-2:0], 1'b0};
        ne_d    = ne_nxt;
        gt_d    = gt_nxt;
        lt_d    = lt_nxt;
        if (count_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          q_d     = a_sh_d;
          flag_d  = (op_q[1] ? gt_nxt : ne_nxt) ^ flag_inverted(op_q);
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      op_q    <= '0;
      ne_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      op_q    <= op_d;
      ne_q    <= ne_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      flag_q  <= flag_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign flag = flag_q;

endmodule

// File: tb/tb_bitserial_logic_seq.sv
// Randomized and directed checks of bitserial_logic_seq against a word-level reference model.
module tb_bitserial_logic_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, flag;
  logic [W-1:0] q;

  int tests = 0;
  int fails = 0;

  bitserial_logic_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .flag  (flag)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [1:0] o);
    case (o)
      2'b00:   return '0;
      2'b01:   return x ^ y;
      2'b10:   return x & y;
      default: return x | y;
    endcase
  endfunction

  function automatic logic ref_flag(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic [1:0] o);
    int unsigned xi, yi;
    xi = x;
    yi = y;
    case (o)
      2'b00:   return xi != yi;
      2'b01:   return xi == yi;
      2'b10:   return xi > yi;
      default: return xi <= yi;
    endcase
  endfunction

  // Issue one op from idle; scramble inputs after acceptance and wait (bounded) for done.
  // lat counts negedges from the start drive to the one where done is seen.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [1:0] oi,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    a = ai; b = bi; op = oi; start = 1'b1;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (q !== '0) begin fails++; $display("FAIL reset_q got %h want 00", q); end
    tests++; if (flag !== 1'b0) begin fails++; $display("FAIL reset_flag got %b want 0", flag); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{8'hC5, 8'hC5, 8'h5A, 8'h01, 8'h12};
    logic [W-1:0] tb [5] = '{8'h3A, 8'h3A, 8'h5A, 8'h80, 8'h13};
    logic [1:0]   to [5] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
    logic [W-1:0] eq [5] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    logic         ef [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], to[i], lat, bc);
      tests++; if (lat !== W + 1) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, W + 1); end
      tests++; if (bc !== W) begin fails++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, W); end
      tests++; if (q !== eq[i]) begin fails++; $display("FAIL dir%0d_q got %h want %h", i, q, eq[i]); end
      tests++; if (flag !== ef[i]) begin fails++; $display("FAIL dir%0d_flag got %b want %b", i, flag, ef[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic [1:0]   ro;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      ro = 2'($urandom);
      do_op(ra, rb, ro, lat, bc);
      tests++; if (lat !== W + 1) begin fails++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, W + 1); end
      tests++; if (q !== ref_q(ra, rb, ro)) begin fails++; $display("FAIL rnd%0d_q op=%b a=%h b=%h got %h want %h", i, ro, ra, rb, q, ref_q(ra, rb, ro)); end
      tests++; if (flag !== ref_flag(ra, rb, ro)) begin fails++; $display("FAIL rnd%0d_flag op=%b a=%h b=%h got %b want %b", i, ro, ra, rb, flag, ref_flag(ra, rb, ro)); end
    end
  endtask

  // start held high with fresh operands every cycle: accepts land every W+1 edges.
  task automatic test_back_to_back();
    localparam int NC = 3 * (W + 1);
    logic [W-1:0] va [NC];
    logic [W-1:0] vb [NC];
    logic [1:0]   vo [NC];
    int ndone = 0;
    int src;
    for (int c = 0; c < NC; c++) begin
      va[c] = W'($urandom); vb[c] = W'($urandom); vo[c] = 2'($urandom);
    end
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < NC; c++) begin
      a = va[c]; b = vb[c]; op = vo[c];
      @(negedge clk);
      if (done === 1'b1) begin
        src = ndone * (W + 1);
        tests++; if (c !== src + W) begin fails++; $display("FAIL b2b_done%0d_cycle got %0d want %0d", ndone, c, src + W); end
        tests++; if (q !== ref_q(va[src], vb[src], vo[src])) begin fails++; $display("FAIL b2b_done%0d_q got %h want %h", ndone, q, ref_q(va[src], vb[src], vo[src])); end
        tests++; if (flag !== ref_flag(va[src], vb[src], vo[src])) begin fails++; $display("FAIL b2b_done%0d_flag got %b want %b", ndone, flag, ref_flag(va[src], vb[src], vo[src])); end
        ndone++;
      end
    end
    start = 1'b0;
    tests++; if (ndone !== 3) begin fails++; $display("FAIL b2b_done_count got %0d want 3", ndone); end
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_after got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] ra, rb;
    int seen = 0;
    int lat, bc;
    ra = W'($urandom); rb = ~ra;
    @(negedge clk);
    a = ra; b = rb; op = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    tests++; if (q !== '0) begin fails++; $display("FAIL rstmid_q got %h want 00", q); end
    tests++; if (flag !== 1'b0) begin fails++; $display("FAIL rstmid_flag got %b want 0", flag); end
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rstmid_no_activity got %0d active cycles want 0", seen); end
    do_op(ra, rb, 2'b11, lat, bc);
    tests++; if (lat !== W + 1) begin fails++; $display("FAIL rstmid_fresh_latency got %0d want %0d", lat, W + 1); end
    tests++; if (q !== ref_q(ra, rb, 2'b11)) begin fails++; $display("FAIL rstmid_fresh_q got %h want %h", q, ref_q(ra, rb, 2'b11)); end
    tests++; if (flag !== ref_flag(ra, rb, 2'b11)) begin fails++; $display("FAIL rstmid_fresh_flag got %b want %b", flag, ref_flag(ra, rb, 2'b11)); end
  endtask

  task automatic test_hold();
    logic [W-1:0] ra, rb, exp_q;
    logic exp_f;
    int lat, bc;
    ra = W'($urandom); rb = W'($urandom);
    do_op(ra, rb, 2'b10, lat, bc);
    exp_q = ref_q(ra, rb, 2'b10);
    exp_f = ref_flag(ra, rb, 2'b10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); op = 2'($urandom); start = 1'b0;
      tests++; if (q !== exp_q || flag !== exp_f || done !== 1'b0) begin
        fails++; $display("FAIL hold%0d got q=%h flag=%b done=%b want q=%h flag=%b done=0", i, q, flag, done, exp_q, exp_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitserial_logic_seq.md
Name: bitserial_logic_seq

Overview:
- Sequencer and final stage for the bitwise/compare datapath.
- Accepts two WIDTH-bit operands and a 2-bit op, then walks them one bit per clock, MSB first, through single-bit logic and compare evaluation.
- Assembles the WIDTH-bit logic result and a single compare flag.
- Applies the deferred flag inversion for op[0]=1, so its consumers see final eq/le semantics directly.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  2  operation select, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when q/flag become valid
- q  out  WIDTH  logic result, held until the next completion
- flag  out  1  compare result, held until the next completion

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, q=0, flag=0, and all internal shift/compare registers cleared.
- Op encoding (q per bit / flag over the whole word):
  - 00: q=0; flag = a!=b
  - 01: q=a^b; flag = a==b (inverted ne)
  - 10: q=a&b; flag = a>b, unsigned
  - 11: q=a|b; flag = a<=b, unsigned (inverted gt)
- States:
  - IDLE: busy=0. start=1 latches a, b, op into shift registers, clears ne_seen/gt_seen/lt_seen, loads count=WIDTH-1, and moves to SHIFT.
  - SHIFT: busy=1. Each cycle evaluates MSB bits sa, sb of the operand shift registers:
    - result shift register <= {res[WIDTH-2:0], qbit}
    - ne_seen |= sa^sb
    - if !gt_seen && !lt_seen: gt_seen <= sa&~sb and lt_seen <= ~sa&sb (first differing bit decides)
    - operands shift left by 1; count decrements
    - at count==0, moves to DONE after that bit is processed.
  - DONE: busy=0, done=1 for exactly this cycle. q and flag are loaded from the result register and the seen bits, with inversion applied when op[0]=1. Next state is IDLE, or SHIFT if start=1 this cycle (back-to-back accepted).
- Latency: start sampled at edge N gives done=1 and valid q/flag during the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles start-to-done. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands are not re-sampled and there is no queueing.
- Changes to a, b, op after acceptance have no effect.
- q and flag change only in the DONE cycle. They hold their previous values during SHIFT and IDLE.
- rst mid-operation aborts immediately: no done pulse, and outputs return to reset values.
- rst and start in the same cycle: rst wins and start is dropped.
- count width is $clog2(WIDTH). No wrap beyond 0; count is reloaded only on acceptance.

Decomposition:
- Shared package bitwise_pkg holds:
  - op constants OP_NE=2'b00, OP_XOR=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - state encoding IDLE/SHIFT/DONE
  - flag-inversion rule: invert when op[0]=1
- One sub-module is natural: serial_cmp_cell. It holds the per-bit combinational function (qbit, next ne/gt/lt seen bits from sa, sb, op and the current seen bits). It is instantiated once; the sequencer holds all registers.

Test Plan:
- Logic op: op=10, a=8'hC5, b=8'h3A, start 1 cycle -> busy for 8 cycles, done pulse 9 cycles after start, q=8'h00, flag=1 (C5>3A).
- Deferred inversion: op=11, a=8'hC5, b=8'h3A -> q=8'hFF, flag=0 (not <=). Then op=01, a=b=8'h5A -> q=8'h00, flag=1 (eq).
- MSB-first priority: op=10, a=8'h01, b=8'h80 -> flag=0 (an OR of per-bit a&~b would wrongly give 1). Then op=00, a=8'h12, b=8'h13 -> q=0, flag=1.
- Handshake: start held high continuously with changing operands -> only the first accepted while busy. The second accepted exactly in the DONE cycle. done pulses are WIDTH+1 cycles apart, and each q matches its latched operands.
- Reset mid-op: assert rst at bit 4 of an op=01 run -> next cycle busy=0, q=0, flag=0, no done. A fresh start afterwards completes normally.
- Hold: after a completion, toggle a/b/op with start=0 for 20 cycles -> q and flag unchanged, done stays 0.
